// File: rtl/core_pkg.sv
// Shared definitions for the MIPS core control path: opcodes, ALU op classes
// and the packed bundle of datapath control strobes.
package core_pkg;

  localparam int OPCODE_BITS = 6;

  // Primary opcodes (instr[31:26]) understood by the main decoder
  localparam logic [OPCODE_BITS-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_BITS-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_BITS-1:0] OP_JAL   = 6'b000011;
  localparam logic [OPCODE_BITS-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_BITS-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_BITS-1:0] OP_XORI  = 6'b001110;
  localparam logic [OPCODE_BITS-1:0] OP_LUI   = 6'b001111;
  localparam logic [OPCODE_BITS-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_BITS-1:0] OP_SW    = 6'b101011;

  // ALU operation classes, {AluOp1, AluOp0}
  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // address generation / lui pass
  localparam logic [1:0] ALUOP_SUB   = 2'b01;  // branch compare
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;  // ALU decodes the funct field
  localparam logic [1:0] ALUOP_LOGIC = 2'b11;  // immediate logic op

  // The 15 control strobes driven toward the datapath
  typedef struct packed {
    logic       reg_dest;
    logic       sign_ext;
    logic       brn;
    logic       bne;
    logic       lui;
    logic       mem_w;
    logic       mem_read;
    logic       mto_reg;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_wr;
    logic       reg_wr2;
    logic       jmp;
    logic       jal;
  } ctrl_t;

  // Bubble: every strobe inactive
  localparam ctrl_t CTRL_NONE = '{
    reg_dest: 1'b0, sign_ext: 1'b0, brn: 1'b0, bne: 1'b0, lui: 1'b0,
    mem_w: 1'b0, mem_read: 1'b0, mto_reg: 1'b0, alu_op: 2'b00,
    alu_src: 1'b0, reg_wr: 1'b0, reg_wr2: 1'b0, jmp: 1'b0, jal: 1'b0
  };

endpackage

// File: rtl/control_decode.sv
// Purely combinational opcode -> control strobe decoder. Unknown opcodes
// decode to a bubble (all strobes low) rather than raising anything.
module control_decode
  import core_pkg::*;
(
  input  logic [OPCODE_BITS-1:0] opcode,
  output ctrl_t                  ctrl
);

  // Opcode lookup; every arm starts from the bubble so unlisted strobes stay low
  always_comb begin
    ctrl = CTRL_NONE;
    case (opcode)
      OP_LW: begin
        ctrl.sign_ext = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.mto_reg  = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.reg_wr   = 1'b1;
        ctrl.alu_op   = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl.sign_ext = 1'b1;
        ctrl.mem_w    = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.alu_op   = ALUOP_ADD;
      end
      OP_RTYPE: begin
        ctrl.reg_dest = 1'b1;
        ctrl.reg_wr   = 1'b1;
        ctrl.alu_op   = ALUOP_FUNCT;
      end
      OP_LUI: begin
        ctrl.lui      = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.reg_wr   = 1'b1;
        ctrl.alu_op   = ALUOP_ADD;
      end
      OP_XORI: begin
        // logic immediates are zero-extended
        ctrl.alu_src  = 1'b1;
        ctrl.reg_wr   = 1'b1;
        ctrl.alu_op   = ALUOP_LOGIC;
      end
      OP_J: begin
        ctrl.jmp      = 1'b1;
      end
      OP_JAL: begin
        // link goes through the second write port so RegWr stays free
        ctrl.jmp      = 1'b1;
        ctrl.jal      = 1'b1;
        ctrl.reg_wr2  = 1'b1;
      end
      OP_BEQ: begin
        ctrl.brn      = 1'b1;
        ctrl.sign_ext = 1'b1;
        ctrl.alu_op   = ALUOP_SUB;
      end
      OP_BNE: begin
        ctrl.bne      = 1'b1;
        ctrl.sign_ext = 1'b1;
        ctrl.alu_op   = ALUOP_SUB;
      end
      default: begin
        ctrl = CTRL_NONE;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Main decoder of the single-issue MIPS core. Decodes the opcode and
// registers the strobes so they line up with the decode/execute boundary.
module control_unit
  import core_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                RegDest,
  output logic                SignExtend,
  output logic                Brn,
  output logic                Bne,
  output logic                lui,
  output logic                MemW,
  output logic                MemRead,
  output logic                MtoReg,
  output logic                AluOp1,
  output logic                AluOp0,
  output logic                AluSrc,
  output logic                RegWr,
  output logic                RegWr2,
  output logic                jmp,
  output logic                jal
);

  ctrl_t ctrl_s;
  ctrl_t ctrl_r;

  control_decode u_decode (
    .opcode (opcode),
    .ctrl   (ctrl_s)
  );

  // Pipeline register for the strobes; async reset forces a bubble at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r <= CTRL_NONE;
    end else begin
      ctrl_r <= ctrl_s;
    end
  end

  assign RegDest    = ctrl_r.reg_dest;
  assign SignExtend = ctrl_r.sign_ext;
  assign Brn        = ctrl_r.brn;
  assign Bne        = ctrl_r.bne;
  assign lui        = ctrl_r.lui;
  assign MemW       = ctrl_r.mem_w;
  assign MemRead    = ctrl_r.mem_read;
  assign MtoReg     = ctrl_r.mto_reg;
  assign AluOp1     = ctrl_r.alu_op[1];
  assign AluOp0     = ctrl_r.alu_op[0];
  assign AluSrc     = ctrl_r.alu_src;
  assign RegWr      = ctrl_r.reg_wr;
  assign RegWr2     = ctrl_r.reg_wr2;
  assign jmp        = ctrl_r.jmp;
  assign jal        = ctrl_r.jal;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: reset behaviour, each defined opcode,
// a full 64-opcode sweep with latency and invariant checks.
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic RegDest, SignExtend, Brn, Bne, lui, MemW, MemRead, MtoReg;
  logic AluOp1, AluOp0, AluSrc, RegWr, RegWr2, jmp, jal;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Bit order: RegDest SignExtend Brn Bne lui MemW MemRead MtoReg AluOp1 AluOp0 AluSrc RegWr RegWr2 jmp jal
  localparam logic [14:0] E_NONE = 15'b000000000000000;
  localparam logic [14:0] E_LW   = 15'b010000110011000;
  localparam logic [14:0] E_SW   = 15'b010001000010000;
  localparam logic [14:0] E_R    = 15'b100000001001000;
  localparam logic [14:0] E_LUI  = 15'b000010000011000;
  localparam logic [14:0] E_XORI = 15'b000000001111000;
  localparam logic [14:0] E_J    = 15'b000000000000010;
  localparam logic [14:0] E_JAL  = 15'b000000000000111;
  localparam logic [14:0] E_BEQ  = 15'b011000000100000;
  localparam logic [14:0] E_BNE  = 15'b010100000100000;

  logic [14:0] outs;
  assign outs = {RegDest, SignExtend, Brn, Bne, lui, MemW, MemRead, MtoReg,
                 AluOp1, AluOp0, AluSrc, RegWr, RegWr2, jmp, jal};

  control_unit #(.OPCODE_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .RegDest    (RegDest),
    .SignExtend (SignExtend),
    .Brn        (Brn),
    .Bne        (Bne),
    .lui        (lui),
    .MemW       (MemW),
    .MemRead    (MemRead),
    .MtoReg     (MtoReg),
    .AluOp1     (AluOp1),
    .AluOp0     (AluOp0),
    .AluSrc     (AluSrc),
    .RegWr      (RegWr),
    .RegWr2     (RegWr2),
    .jmp        (jmp),
    .jal        (jal)
  );

  // 10 ns clock, rising edge active
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [14:0] got, input logic [14:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Hand-written decode table of expected strobes
  function automatic logic [14:0] exp_of(input logic [5:0] op);
    case (op)
      6'b100011: exp_of = E_LW;
      6'b101011: exp_of = E_SW;
      6'b000000: exp_of = E_R;
      6'b001111: exp_of = E_LUI;
      6'b001110: exp_of = E_XORI;
      6'b000010: exp_of = E_J;
      6'b000011: exp_of = E_JAL;
      6'b000100: exp_of = E_BEQ;
      6'b000101: exp_of = E_BNE;
      default:   exp_of = E_NONE;
    endcase
  endfunction

  task automatic check_inv(input string tag);
    check_val({tag, "_mem_excl"}, {14'd0, MemW & MemRead}, 15'd0);
    check_val({tag, "_wr_excl"},  {14'd0, RegWr & RegWr2}, 15'd0);
    check_val({tag, "_pc_excl"},  {14'd0, (Brn & Bne) | (Brn & jmp) | (Bne & jmp)}, 15'd0);
  endtask

  logic [14:0] prev_exp;
  int          zero_cnt;

  initial begin
    rst_n  = 1'b0;
    opcode = 6'b100011;

    // Held in reset with lw on the input: nothing may leak through
    repeat (3) begin
      @(negedge clk);
      check_val("reset_hold", outs, E_NONE);
    end

    // Release away from the edge; first decode appears after the next rising edge
    rst_n = 1'b1;
    #1 check_val("post_release_pre_edge", outs, E_NONE);
    @(negedge clk);
    check_val("lw", outs, E_LW);
    opcode = 6'b101011;
    @(negedge clk);
    check_val("sw", outs, E_SW);

    opcode = 6'b000000;  @(negedge clk); check_val("rtype", outs, E_R);
    opcode = 6'b001111;  @(negedge clk); check_val("lui",   outs, E_LUI);
    opcode = 6'b001110;  @(negedge clk); check_val("xori",  outs, E_XORI);
    opcode = 6'b000010;  @(negedge clk); check_val("j",     outs, E_J);
    opcode = 6'b000011;  @(negedge clk); check_val("jal",   outs, E_JAL);
    opcode = 6'b000100;  @(negedge clk); check_val("beq",   outs, E_BEQ);
    opcode = 6'b000101;  @(negedge clk); check_val("bne",   outs, E_BNE);

    // Mid-stream reset: clears without a clock edge
    opcode = 6'b000000;
    @(negedge clk);
    check_val("before_midreset", outs, E_R);
    #2 rst_n = 1'b0;
    #1 check_val("midreset_async", outs, E_NONE);
    @(negedge clk);
    check_val("midreset_hold", outs, E_NONE);
    rst_n  = 1'b1;
    opcode = 6'b001111;
    #1 check_val("midreset_release", outs, E_NONE);
    @(negedge clk);
    check_val("after_midreset", outs, E_LUI);

    // Sweep every opcode: one-cycle latency, decode value and invariants
    prev_exp = E_LUI;
    zero_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      opcode = 6'(i);
      #1 check_val($sformatf("hold_op%0d", i), outs, prev_exp);
      @(negedge clk);
      check_val($sformatf("sweep_op%0d", i), outs, exp_of(6'(i)));
      check_inv($sformatf("inv_op%0d", i));
      if (outs == E_NONE) begin
        zero_cnt++;
      end else begin
        zero_cnt = zero_cnt;
      end
      prev_exp = exp_of(6'(i));
    end
    check_val("bubble_count", 15'(zero_cnt), 15'd55);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
